q_max_selector: RTL and testbench

Finds the maximum target-network Q-value, Q'max, over one state's action outputs and reports it to the loss stage. Q-values arrive serially, one per valid cycle, from the target-network output layer. The block compares them in IEEE-754 single precision and emits Q'max and its action index as a one-cycle valid pulse. That pulse drives the loss stage's i_q_max / i_q_max_valid inputs, which feed the gamma multiplier.

---
 rtl/q_max_selector.sv | 150 +++++++++++++++
 tb/tb_q_max_selector.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/q_max_selector.sv
// q_max_selector
// Finds the largest IEEE-754 single-precision Q-value in each frame of
// NUM_ACTIONS serially delivered samples and reports it, together with its
// action index, as a one-cycle valid pulse for the loss stage.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - asynchronous active-high reset
//   i_clear        - synchronous abort of a partially received frame
//   i_q_valid      - i_q_value carries a sample this cycle (always accepted)
//   i_q_value      - Q-value, delivered in action order 0..NUM_ACTIONS-1
//   o_q_max        - maximum Q-value of the last completed frame
//   o_action_idx   - action index of o_q_max within its frame
//   o_q_max_valid  - one-cycle pulse marking a freshly completed frame
module q_max_selector #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ACTIONS = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_q_valid,
  input  logic [DATA_WIDTH-1:0] i_q_value,
  output logic [DATA_WIDTH-1:0] o_q_max,
  output logic [IDX_WIDTH-1:0]  o_action_idx,
  output logic                  o_q_max_valid
);

  localparam int MANT_WIDTH = 23;
  localparam int EXP_WIDTH  = DATA_WIDTH - 1 - MANT_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ACTIONS - 1);

  // The frame position alone tells whether a frame is in progress.
  typedef enum logic {
    IDLE,
    ACC
  } state_e;

  logic [IDX_WIDTH-1:0]  cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0] run_max_q,  run_max_d;
  logic [IDX_WIDTH-1:0]  run_idx_q,  run_idx_d;
  logic [DATA_WIDTH-1:0] q_max_q,    q_max_d;
  logic [IDX_WIDTH-1:0]  idx_q,      idx_d;
  logic                  valid_q,    valid_d;

  state_e               state;
  state_e               state_eff;
  logic [IDX_WIDTH-1:0] cnt_eff;
  logic                 take;

  // Strict floating-point greater-than. A NaN candidate never wins; two zeros
  // of either sign are equal; otherwise sign decides, then magnitude, with the
  // magnitude order inverted for negative numbers.
  function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                              input logic [DATA_WIDTH-1:0] b);
    logic a_nan;
    logic a_neg;
    logic b_neg;
    logic [DATA_WIDTH-2:0] a_mag;
    logic [DATA_WIDTH-2:0] b_mag;
    a_neg = a[DATA_WIDTH-1];
    b_neg = b[DATA_WIDTH-1];
    a_mag = a[DATA_WIDTH-2:0];
    b_mag = b[DATA_WIDTH-2:0];
    a_nan = (&a[DATA_WIDTH-2:MANT_WIDTH]) && (|a[MANT_WIDTH-1:0]);
    if (a_nan) begin
      gt = 1'b0;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      gt = 1'b0;
    end else if (a_neg != b_neg) begin
      gt = !a_neg;
    end else if (!a_neg) begin
      gt = (a_mag > b_mag);
    end else begin
      gt = (a_mag < b_mag);
    end
  endfunction

  assign state = (cnt_q == '0) ? IDLE : ACC;

  // State, running max and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      q_max_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      q_max_q   <= q_max_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state logic. A clear makes the current cycle behave as if no frame
  // were in progress, so a sample arriving with it becomes action 0.
  always_comb begin
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    q_max_d   = q_max_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    state_eff = i_clear ? IDLE : state;
    cnt_eff   = i_clear ? '0 : cnt_q;
    take      = gt(i_q_value, run_max_q);

    if (i_clear) begin
      cnt_d = '0;
    end

    if (i_q_valid) begin
      case (state_eff)
        IDLE: begin
          run_max_d = i_q_value;
          run_idx_d = '0;
          cnt_d     = IDX_WIDTH'(1);
        end
        ACC: begin
          if (cnt_eff == LAST_IDX) begin
            q_max_d = take ? i_q_value : run_max_q;
            idx_d   = take ? cnt_eff : run_idx_q;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            if (take) begin
              run_max_d = i_q_value;
              run_idx_d = cnt_eff;
            end
            cnt_d = cnt_eff + IDX_WIDTH'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  assign o_q_max       = q_max_q;
  assign o_action_idx  = idx_q;
  assign o_q_max_valid = valid_q;

endmodule

// File: tb/tb_q_max_selector.sv
// Testbench for q_max_selector: directed frames with hand-computed results,
// checked with immediate assertions.
module tb_q_max_selector;

  logic        clk;
  logic        rst;
  logic        i_clear;
  logic        i_q_valid;
  logic [31:0] i_q_value;
  logic [31:0] o_q_max;
  logic [1:0]  o_action_idx;
  logic        o_q_max_valid;

  int testsRun    = 0;
  int testsFailed = 0;
  int pulseCount  = 0;
  int cycleNum    = 0;
  int lastPulse   = -100;
  int pulseGap    = 0;
  int pulseBase   = 0;

  q_max_selector #(
    .DATA_WIDTH (32),
    .NUM_ACTIONS(4),
    .IDX_WIDTH  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (i_clear),
    .i_q_valid    (i_q_valid),
    .i_q_value    (i_q_value),
    .o_q_max      (o_q_max),
    .o_action_idx (o_action_idx),
    .o_q_max_valid(o_q_max_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts output pulses and the cycle distance between consecutive ones.
  always @(posedge clk) begin
    #2;
    cycleNum++;
    if (o_q_max_valid === 1'b1) begin
      pulseCount++;
      pulseGap  = cycleNum - lastPulse;
      lastPulse = cycleNum;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs starting at a falling edge and returns at the
  // next falling edge, when outputs of that cycle's rising edge are settled.
  task automatic applyStimulus(input logic v, input logic [31:0] val,
                               input logic clr);
    i_q_valid = v;
    i_q_value = val;
    i_clear   = clr;
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
    applyStimulus(1'b1, a, 1'b0);
    applyStimulus(1'b1, b, 1'b0);
    applyStimulus(1'b1, c, 1'b0);
    applyStimulus(1'b1, d, 1'b0);
  endtask

  // Checks the pulse and result, then one idle cycle to confirm width 1.
  task automatic checkResult(input string tag, input logic [31:0] expMax,
                             input logic [1:0] expIdx);
    checkOutput({tag, "_valid"}, {31'b0, o_q_max_valid}, 32'd1);
    checkOutput({tag, "_max"}, o_q_max, expMax);
    checkOutput({tag, "_idx"}, {30'b0, o_action_idx}, {30'b0, expIdx});
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput({tag, "_width"}, {31'b0, o_q_max_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    i_clear   = 1'b0;
    i_q_valid = 1'b0;
    i_q_value = 32'h0;
    #1;
    checkOutput("reset_max", o_q_max, 32'h0);
    checkOutput("reset_idx", {30'b0, o_action_idx}, 32'd0);
    checkOutput("reset_valid", {31'b0, o_q_max_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Mixed signs: 1, 2, -1, 0.5
    sendFrame(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000);
    checkResult("mixed", 32'h40000000, 2'd1);

    // All negative: -1, -2, -0.5, -3
    sendFrame(32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000);
    checkResult("allneg", 32'hBF000000, 2'd2);

    // Signed zeros and a tie: -0, +0, 1, 1
    sendFrame(32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800000);
    checkResult("tie", 32'h3F800000, 2'd2);

    // Only signed zeros: the first one stands
    sendFrame(32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000);
    checkResult("zeros", 32'h80000000, 2'd0);

    // Back-to-back frames with no bubble
    sendFrame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000);
    checkOutput("b2b_a_valid", {31'b0, o_q_max_valid}, 32'd1);
    checkOutput("b2b_a_max", o_q_max, 32'h40400000);
    checkOutput("b2b_a_idx", {30'b0, o_action_idx}, 32'd2);
    sendFrame(32'hBF800000, 32'hBF800000, 32'hC0000000, 32'h40400000);
    checkOutput("b2b_gap", 32'(pulseGap), 32'd4);
    checkResult("b2b_b", 32'h40400000, 2'd3);

    // Partial frame aborted by a clear that carries a new sample 0
    pulseBase = pulseCount;
    applyStimulus(1'b1, 32'h40800000, 1'b0);
    applyStimulus(1'b1, 32'h40A00000, 1'b0);
    applyStimulus(1'b1, 32'h3F800000, 1'b1);
    checkOutput("clr_hold_max", o_q_max, 32'h40400000);
    checkOutput("clr_hold_idx", {30'b0, o_action_idx}, 32'd3);
    checkOutput("clr_novalid", {31'b0, o_q_max_valid}, 32'd0);
    applyStimulus(1'b1, 32'h00000000, 1'b0);
    applyStimulus(1'b1, 32'h00000000, 1'b0);
    applyStimulus(1'b1, 32'h00000000, 1'b0);
    checkResult("clr", 32'h3F800000, 2'd0);
    checkOutput("clr_pulses", 32'(pulseCount - pulseBase), 32'd1);

    // Partial frame aborted by reset
    pulseBase = pulseCount;
    applyStimulus(1'b1, 32'h41000000, 1'b0);
    applyStimulus(1'b1, 32'h41100000, 1'b0);
    i_q_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_max", o_q_max, 32'h0);
    checkOutput("rst_idx", {30'b0, o_action_idx}, 32'd0);
    checkOutput("rst_valid", {31'b0, o_q_max_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sendFrame(32'h40000000, 32'h3F800000, 32'h00000000, 32'h00000000);
    checkResult("rst", 32'h40000000, 2'd0);
    checkOutput("rst_pulses", 32'(pulseCount - pulseBase), 32'd1);

    // NaN at index 1 never wins
    sendFrame(32'hBF800000, 32'h7FC00000, 32'hC0000000, 32'hC0400000);
    checkResult("nan", 32'hBF800000, 2'd0);

    // Outputs hold across idle cycles
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("hold_max", o_q_max, 32'hBF800000);
    checkOutput("hold_valid", {31'b0, o_q_max_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
